// File: rtl/addsub32_seq_if.sv
// Request, adder-drive and result signals of the 32-bit add/sub sequencer.
// The sequencer uses the slave modport; the producer/consumer/adder side uses master.
interface addsub32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        in_acc;
  logic        acc_clr;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic        add_op;
  logic [15:0] add_ans;
  logic        add_carry;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr,
    output in_ready,
    output add_a, add_b, add_cin, add_op,
    input  add_ans, add_carry,
    output out_valid, out_res, out_carry, out_ovf, out_zero,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr,
    input  in_ready,
    input  add_a, add_b, add_cin, add_op,
    output add_ans, add_carry,
    input  out_valid, out_res, out_carry, out_ovf, out_zero,
    output out_ready
  );
endinterface

// File: rtl/addsub32_seq.sv
// 32-bit add/subtract built from two passes through an external 16-bit add/sub
// datapath (low half, then high half), with a result accumulator.
//
// state | meaning
// IDLE  | ready for a request; accumulator clear honoured here
// LO    | adder works on bits 15:0, carry captured into c_reg
// HI    | adder works on bits 31:16, flags computed
// DONE  | result presented until the consumer takes it
module addsub32_seq (
  input  logic            clk,
  input  logic            rst,
  addsub32_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_reg, b_reg, acc, res;
  logic        op_reg, c_reg;
  logic        carry_reg, ovf_reg, zero_reg;
  logic        take;

  assign take = bus.in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 16'h0000;
    bus.add_b     = 16'h0000;
    bus.add_cin   = 1'b0;
    bus.add_op    = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      LO: begin
        bus.add_a   = a_reg[15:0];
        bus.add_b   = b_reg[15:0];
        bus.add_op  = op_reg;
        bus.add_cin = op_reg;
      end
      HI: begin
        bus.add_a   = a_reg[31:16];
        bus.add_b   = b_reg[31:16];
        bus.add_op  = op_reg;
        bus.add_cin = c_reg;
      end
      DONE: bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 1'b0;
      c_reg     <= 1'b0;
      acc       <= '0;
      res       <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.acc_clr) acc <= '0;
          if (take) begin
            // A same-cycle clear beats the accumulator as the A source
            a_reg  <= bus.in_acc ? (bus.acc_clr ? 32'h0 : acc) : bus.in_a;
            b_reg  <= bus.in_b;
            op_reg <= bus.in_op;
          end
        end
        LO: begin
          res[15:0] <= bus.add_ans;
          c_reg     <= bus.add_carry;
        end
        HI: begin
          res[31:16] <= bus.add_ans;
          carry_reg  <= bus.add_carry;
          ovf_reg    <= (a_reg[31] == (b_reg[31] ^ op_reg)) &&
                        (bus.add_ans[15] != a_reg[31]);
          zero_reg   <= (res[15:0] == 16'h0000) && (bus.add_ans == 16'h0000);
        end
        DONE: if (bus.out_ready) acc <= res;
        default: ;
      endcase
    end
  end

  assign bus.out_res   = res;
  assign bus.out_carry = carry_reg;
  assign bus.out_ovf   = ovf_reg;
  assign bus.out_zero  = zero_reg;

endmodule
